// File: rtl/alu_issue_stage_pkg.sv
// Shared select codes, opcode fields and FSM states
// for the ALU issue stage and its decoder.
package alu_issue_stage_pkg;

  typedef enum logic [4:0] {
    SEL_ADD  = 5'd0,
    SEL_SUB  = 5'd1,
    SEL_MUL  = 5'd2,
    SEL_DIVU = 5'd3,
    SEL_SLL  = 5'd4,
    SEL_SRL  = 5'd5,
    SEL_AND  = 5'd8,
    SEL_OR   = 5'd9,
    SEL_XOR  = 5'd10,
    SEL_SLTU = 5'd13,
    SEL_SLT  = 5'd14,
    SEL_SRA  = 5'd15,
    SEL_IDLE = 5'd31
  } alu_sel_e;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_CAPT,
    ST_DONE
  } state_e;

  localparam int CNT_W = 3;

  function automatic logic is_shift(
    input logic [4:0] s
  );
    return (s == SEL_SLL) ||
           (s == SEL_SRL) ||
           (s == SEL_SRA);
  endfunction

endpackage

// File: rtl/alu_issue_stage_decoder.sv
// Combinational RV32IM decode into ALU select code
// and A/B operands; unsupported encodings are illegal.
module alu_op_decoder
  import alu_issue_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  output logic [4:0]      o_sel,
  output logic [XLEN-1:0] o_a,
  output logic [XLEN-1:0] o_b,
  output logic [4:0]      o_rd,
  output logic            o_illegal
);

  logic [6:0]      w_opc;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_u;
  logic [4:0]      w_sel;

  assign w_opc   = i_instr[6:0];
  assign w_f3    = i_instr[14:12];
  assign w_f7    = i_instr[31:25];
  assign w_imm_i = {{(XLEN-12){i_instr[31]}},
                    i_instr[31:20]};
  assign w_imm_u = {i_instr[31:12], 12'b0};

  always_comb begin
    w_sel = SEL_IDLE;
    o_a   = i_rs1;
    o_b   = i_rs2;
    unique case (w_opc)
      OP_R: begin
        unique case (w_f7)
          F7_BASE: begin
            unique case (w_f3)
              F3_ADD:  w_sel = SEL_ADD;
              F3_SLL:  w_sel = SEL_SLL;
              F3_SLT:  w_sel = SEL_SLT;
              F3_SLTU: w_sel = SEL_SLTU;
              F3_XOR:  w_sel = SEL_XOR;
              F3_SR:   w_sel = SEL_SRL;
              F3_OR:   w_sel = SEL_OR;
              F3_AND:  w_sel = SEL_AND;
            endcase
          end
          F7_ALT: begin
            if (w_f3 == F3_ADD)
              w_sel = SEL_SUB;
            else if (w_f3 == F3_SR)
              w_sel = SEL_SRA;
          end
          F7_MUL: begin
            if (w_f3 == F3_ADD)
              w_sel = SEL_MUL;
            else if (w_f3 == F3_SR)
              w_sel = SEL_DIVU;
          end
          default: ;
        endcase
        // the ALU shifts by all of B
        if (is_shift(w_sel))
          o_b = {{(XLEN-5){1'b0}}, i_rs2[4:0]};
      end
      OP_I: begin
        o_b = w_imm_i;
        unique case (w_f3)
          F3_ADD:  w_sel = SEL_ADD;
          F3_SLT:  w_sel = SEL_SLT;
          F3_SLTU: w_sel = SEL_SLTU;
          F3_XOR:  w_sel = SEL_XOR;
          F3_OR:   w_sel = SEL_OR;
          F3_AND:  w_sel = SEL_AND;
          F3_SLL: begin
            if (w_f7 == F7_BASE)
              w_sel = SEL_SLL;
          end
          F3_SR: begin
            if (w_f7 == F7_BASE)
              w_sel = SEL_SRL;
            else if (w_f7 == F7_ALT)
              w_sel = SEL_SRA;
          end
        endcase
        if (is_shift(w_sel))
          o_b = {{(XLEN-5){1'b0}},
                 i_instr[24:20]};
      end
      OP_LUI: begin
        w_sel = SEL_ADD;
        o_a   = '0;
        o_b   = w_imm_u;
      end
      OP_AUIPC: begin
        w_sel = SEL_ADD;
        o_a   = i_pc;
        o_b   = w_imm_u;
      end
      default: ;
    endcase
  end

  assign o_sel     = w_sel;
  assign o_rd      = i_instr[11:7];
  assign o_illegal = (w_sel == SEL_IDLE);

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage for the PE's ALU: accept, decode,
// wait fixed ALU latency, return result.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int ALU_LAT = 1,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_val,
  input  logic [XLEN-1:0] in_rs2_val,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [4:0]      alu_sel,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_complete,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            out_we,
  output logic            out_illegal
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [4:0]       r_sel;
  logic [XLEN-1:0]  r_a;
  logic [XLEN-1:0]  r_b;
  logic [XLEN-1:0]  r_result;
  logic [4:0]       r_rd;
  logic             r_we;
  logic             r_illegal;

  logic [4:0]       w_sel;
  logic [XLEN-1:0]  w_a;
  logic [XLEN-1:0]  w_b;
  logic [4:0]       w_rd;
  logic             w_illegal;
  logic             w_accept;
  logic [XLEN-1:0]  w_capt;

  alu_op_decoder #(
    .XLEN(XLEN)
  ) u_dec (
    .i_instr  (in_instr),
    .i_pc     (in_pc),
    .i_rs1    (in_rs1_val),
    .i_rs2    (in_rs2_val),
    .o_sel    (w_sel),
    .o_a      (w_a),
    .o_b      (w_b),
    .o_rd     (w_rd),
    .o_illegal(w_illegal)
  );

  assign w_accept = in_valid && in_ready;

  // divide-by-zero reports incomplete; keep all-ones quotient
  assign w_capt =
    ((r_sel == SEL_DIVU) && !alu_complete)
      ? '1 : alu_result;

  always_ff @(posedge clk) begin
    if (reset)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid)
          w_state_nxt = w_illegal ? ST_DONE
                                  : ST_EXEC;
      end
      ST_EXEC: begin
        if (r_cnt == CNT_W'(1))
          w_state_nxt = ST_CAPT;
      end
      ST_CAPT: w_state_nxt = ST_DONE;
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready)
          w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_sel     <= SEL_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_result  <= '0;
      r_rd      <= '0;
      r_we      <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_rd      <= w_rd;
            r_illegal <= w_illegal;
            r_result  <= '0;
            r_we      <= 1'b0;
            r_cnt     <= CNT_W'(ALU_LAT);
            if (!w_illegal) begin
              r_sel <= w_sel;
              r_a   <= w_a;
              r_b   <= w_b;
            end
          end
        end
        ST_EXEC: r_cnt <= r_cnt - CNT_W'(1);
        ST_CAPT: begin
          r_result <= w_capt;
          r_we     <= (r_rd != 5'd0);
          r_sel    <= SEL_IDLE;
        end
        ST_DONE: ;
      endcase
    end
  end

  assign alu_sel     = r_sel;
  assign alu_a       = r_a;
  assign alu_b       = r_b;
  assign out_result  = r_result;
  assign out_rd      = r_rd;
  assign out_we      = r_we;
  assign out_illegal = r_illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed table, reset
// abort sequence and random mnemonic-level checks.
module tb_alu_issue_stage;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] in_rs1_val;
  logic [31:0] in_rs2_val;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_sel;
  logic [31:0] alu_result;
  logic        alu_complete;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_we;
  logic        out_illegal;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(
    .ALU_LAT(LAT),
    .XLEN   (32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .in_rs1_val  (in_rs1_val),
    .in_rs2_val  (in_rs2_val),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_sel     (alu_sel),
    .alu_result  (alu_result),
    .alu_complete(alu_complete),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_rd      (out_rd),
    .out_we      (out_we),
    .out_illegal (out_illegal)
  );

  // stand-in ALU with LAT cycles of latency
  function automatic logic [31:0] alu_fn(
    input logic [4:0] s,
    input logic [31:0] a, b
  );
    case (s)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a * b;
      5'd3:  return (b == 0) ? 32'hFFFFFFFF : a / b;
      5'd4:  return a << b;
      5'd5:  return a >> b;
      5'd8:  return a & b;
      5'd9:  return a | b;
      5'd10: return a ^ b;
      5'd13: return {31'b0, a < b};
      5'd14: return {31'b0, $signed(a) < $signed(b)};
      5'd15: return $signed(a) >>> b;
      default: return 32'h0;
    endcase
  endfunction

  logic [31:0] pipe_r [LAT];
  logic        pipe_c [LAT];

  always @(posedge clk) begin
    pipe_r[0] <= alu_fn(alu_sel, alu_a, alu_b);
    pipe_c[0] <= !(alu_sel == 5'd3 && alu_b == 0);
    for (int i = 1; i < LAT; i++) begin
      pipe_r[i] <= pipe_r[i-1];
      pipe_c[i] <= pipe_c[i-1];
    end
  end

  assign alu_result   = pipe_r[LAT-1];
  assign alu_complete = pipe_c[LAT-1];

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h",
               nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rt(
    input logic [6:0] f7,
    input logic [2:0] f3,
    input logic [4:0] rd
  );
    return {f7, 5'd2, 5'd1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] it(
    input logic [11:0] imm,
    input logic [2:0] f3,
    input logic [4:0] rd
  );
    return {imm, 5'd1, f3, rd, 7'h13};
  endfunction

  // issue one instruction and check the full transaction
  task automatic issue(
    input logic [31:0] instr, pc, rs1, rs2,
    input logic [31:0] eres,
    input logic [4:0]  erd,
    input bit          ewe, eill,
    input int          hold,
    input bit          chk_op,
    input logic [4:0]  esel,
    input logic [31:0] ea, eb
  );
    int n;
    bit ok;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", {31'b0, in_ready}, 1);
    in_instr   = instr;
    in_pc      = pc;
    in_rs1_val = rs1;
    in_rs2_val = rs2;
    in_valid   = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = (hold == 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1 && chk_op) begin
        chk("alu_sel", {27'b0, alu_sel},
            {27'b0, esel});
        if (!eill) begin
          chk("alu_a", alu_a, ea);
          chk("alu_b", alu_b, eb);
        end
      end
    end while (!out_valid && n < 40);
    chk("latency", n, eill ? 1 : LAT + 2);
    chk("in_ready_busy", {31'b0, in_ready}, 0);
    chk("out_result", out_result, eres);
    chk("out_we", {31'b0, out_we}, {31'b0, ewe});
    chk("out_illegal", {31'b0, out_illegal},
        {31'b0, eill});
    if (!eill)
      chk("out_rd", {27'b0, out_rd}, {27'b0, erd});
    if (hold > 0) begin
      ok = 1'b1;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        ok &= out_valid && !in_ready &&
              (out_result == eres);
      end
      chk("hold_stable", {31'b0, ok}, 1);
      out_ready = 1'b1;
    end
    @(negedge clk);
    chk("after_hs", {30'b0, in_ready, out_valid},
        32'd2);
  endtask

  // expected behaviour from the instruction mnemonic
  task automatic gen(
    input int k,
    input logic [4:0] rd,
    input logic [31:0] rs1, rs2, pc,
    input logic [11:0] imm,
    input logic [19:0] uimm,
    output logic [31:0] ins,
    output logic [31:0] res,
    output bit ill
  );
    logic [31:0] si;
    logic [4:0]  sh;
    si  = {{20{imm[11]}}, imm};
    sh  = imm[4:0];
    ill = 1'b0;
    res = 32'h0;
    case (k)
      0:  begin ins = rt(7'h00, 3'd0, rd); res = rs1 + rs2; end
      1:  begin ins = rt(7'h20, 3'd0, rd); res = rs1 - rs2; end
      2:  begin ins = rt(7'h00, 3'd1, rd); res = rs1 << rs2[4:0]; end
      3:  begin ins = rt(7'h00, 3'd2, rd);
                res = {31'b0, $signed(rs1) < $signed(rs2)}; end
      4:  begin ins = rt(7'h00, 3'd3, rd); res = {31'b0, rs1 < rs2}; end
      5:  begin ins = rt(7'h00, 3'd4, rd); res = rs1 ^ rs2; end
      6:  begin ins = rt(7'h00, 3'd5, rd); res = rs1 >> rs2[4:0]; end
      7:  begin ins = rt(7'h20, 3'd5, rd);
                res = $signed(rs1) >>> rs2[4:0]; end
      8:  begin ins = rt(7'h00, 3'd6, rd); res = rs1 | rs2; end
      9:  begin ins = rt(7'h00, 3'd7, rd); res = rs1 & rs2; end
      10: begin ins = rt(7'h01, 3'd0, rd); res = rs1 * rs2; end
      11: begin ins = rt(7'h01, 3'd5, rd);
                res = (rs2 == 0) ? 32'hFFFFFFFF : rs1 / rs2; end
      12: begin ins = it(imm, 3'd0, rd); res = rs1 + si; end
      13: begin ins = it(imm, 3'd2, rd);
                res = {31'b0, $signed(rs1) < $signed(si)}; end
      14: begin ins = it(imm, 3'd3, rd); res = {31'b0, rs1 < si}; end
      15: begin ins = it(imm, 3'd4, rd); res = rs1 ^ si; end
      16: begin ins = it(imm, 3'd6, rd); res = rs1 | si; end
      17: begin ins = it(imm, 3'd7, rd); res = rs1 & si; end
      18: begin ins = it({7'h00, sh}, 3'd1, rd); res = rs1 << sh; end
      19: begin ins = it({7'h00, sh}, 3'd5, rd); res = rs1 >> sh; end
      20: begin ins = it({7'h20, sh}, 3'd5, rd);
                res = $signed(rs1) >>> sh; end
      21: begin ins = {uimm, rd, 7'h37}; res = {uimm, 12'b0}; end
      22: begin ins = {uimm, rd, 7'h17}; res = pc + {uimm, 12'b0}; end
      23: begin ins = rt(7'h01, 3'd4, rd); ill = 1'b1; end
      24: begin ins = rt(7'h01, 3'd7, rd); ill = 1'b1; end
      25: begin ins = rt(7'h01, 3'd1, rd); ill = 1'b1; end
      26: begin ins = {7'h0, 5'd2, 5'd1, 3'd0, rd, 7'h63}; ill = 1'b1; end
      default: begin ins = it({7'h20, sh}, 3'd1, rd); ill = 1'b1; end
    endcase
  endtask

  typedef struct {
    logic [31:0] instr, pc, rs1, rs2;
    logic [31:0] res;
    logic [4:0]  rd;
    bit          we, ill;
    logic [4:0]  sel;
    logic [31:0] a, b;
    int          hold;
  } vec_t;

  vec_t vt [15];

  initial begin
    logic [31:0] ins, res, rs1, rs2, pc;
    logic [4:0]  rd;
    bit          ill, ok;
    int          k;

    vt[0]  = '{rt(7'h00, 3'd0, 5'd3), 0, 5, 7,
               12, 3, 1, 0, 0, 5, 7, 0};
    vt[1]  = '{it({7'h20, 5'd4}, 3'd5, 5'd4), 0,
               32'hF0000000, 0, 32'hFF000000, 4, 1, 0,
               15, 32'hF0000000, 4, 0};
    vt[2]  = '{rt(7'h20, 3'd5, 5'd4), 0,
               32'hF0000000, 32'h24, 32'hFF000000, 4,
               1, 0, 15, 32'hF0000000, 4, 0};
    vt[3]  = '{{20'h12345, 5'd5, 7'h37}, 0,
               32'hDEADBEEF, 0, 32'h12345000, 5, 1, 0,
               0, 0, 32'h12345000, 0};
    vt[4]  = '{{20'h12345, 5'd5, 7'h17}, 32'h100,
               0, 0, 32'h12345100, 5, 1, 0,
               0, 32'h100, 32'h12345000, 0};
    vt[5]  = '{rt(7'h01, 3'd5, 5'd6), 0, 32'h123, 0,
               32'hFFFFFFFF, 6, 1, 0, 3, 32'h123, 0, 0};
    vt[6]  = '{rt(7'h01, 3'd4, 5'd6), 0, 9, 3,
               0, 6, 0, 1, 5'h1F, 0, 0, 0};
    vt[7]  = '{it(12'd1, 3'd0, 5'd0), 0, 0, 0,
               1, 0, 0, 0, 0, 0, 1, 5};
    vt[8]  = '{rt(7'h01, 3'd0, 5'd7), 0, 3,
               32'hFFFFFFFE, 32'hFFFFFFFA, 7, 1, 0,
               2, 3, 32'hFFFFFFFE, 0};
    vt[9]  = '{rt(7'h20, 3'd0, 5'd9), 0, 5, 7,
               32'hFFFFFFFE, 9, 1, 0, 1, 5, 7, 0};
    vt[10] = '{it(12'hFFF, 3'd2, 5'd10), 0,
               32'hFFFFFFFB, 0, 1, 10, 1, 0,
               14, 32'hFFFFFFFB, 32'hFFFFFFFF, 0};
    vt[11] = '{rt(7'h00, 3'd3, 5'd11), 0, 1,
               32'hFFFFFFFF, 1, 11, 1, 0, 13, 1,
               32'hFFFFFFFF, 0};
    vt[12] = '{{12'd0, 5'd1, 3'd2, 5'd12, 7'h03}, 0,
               0, 0, 0, 12, 0, 1, 5'h1F, 0, 0, 0};
    vt[13] = '{it({7'h01, 5'd3}, 3'd1, 5'd8), 0,
               1, 0, 0, 8, 0, 1, 5'h1F, 0, 0, 0};
    vt[14] = '{rt(7'h00, 3'd1, 5'd13), 0, 1,
               32'h21, 2, 13, 1, 0, 4, 1, 1, 0};

    reset      = 1'b1;
    in_valid   = 1'b0;
    in_instr   = 0;
    in_pc      = 0;
    in_rs1_val = 0;
    in_rs2_val = 0;
    out_ready  = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    chk("rst_in_ready", {31'b0, in_ready}, 1);
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_outs", {out_result[30:0] | alu_a[30:0] |
        alu_b[30:0], out_rd == 0, out_we, out_illegal},
        0 | 32'h4);
    chk("rst_alu_sel", {27'b0, alu_sel}, 32'h1F);

    for (int i = 0; i < 15; i++)
      issue(vt[i].instr, vt[i].pc, vt[i].rs1,
            vt[i].rs2, vt[i].res, vt[i].rd,
            vt[i].we, vt[i].ill, vt[i].hold, 1'b1,
            vt[i].sel, vt[i].a, vt[i].b);

    // reset while EXEC: instruction is abandoned
    in_instr   = rt(7'h00, 3'd0, 5'd3);
    in_rs1_val = 1;
    in_rs2_val = 2;
    in_valid   = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_exec_idle", {31'b0, in_ready}, 1);
    chk("rst_exec_sel", {27'b0, alu_sel}, 32'h1F);
    chk("rst_exec_valid", {31'b0, out_valid}, 0);
    ok = 1'b1;
    repeat (6) begin
      @(negedge clk);
      ok &= !out_valid;
    end
    chk("rst_no_capture", {31'b0, ok}, 1);
    issue(rt(7'h00, 3'd0, 5'd3), 0, 1, 2, 3, 3,
          1, 0, 0, 1'b1, 5'd0, 1, 2);

    for (int j = 0; j < 80; j++) begin
      k   = $urandom_range(0, 27);
      rd  = 5'($urandom_range(0, 31));
      rs1 = $urandom;
      rs2 = ($urandom_range(0, 3) == 0) ? 0 : $urandom;
      pc  = $urandom & 32'hFFFFFFFC;
      gen(k, rd, rs1, rs2, pc, 12'($urandom),
          20'($urandom), ins, res, ill);
      issue(ins, pc, rs1, rs2, res, rd,
            !ill && rd != 0, ill,
            $urandom_range(0, 3), 1'b0, 5'd0, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
